// File: rtl/bus_arbiter.sv
// bus_arbiter: two-port round-robin line-read arbiter for the system bus.
// Port 0 = instruction fetch, port 1 = data memory.
//
// Ports:
//   clk, reset             clock, async active-high reset
//   mN_req/addr/tag        requester N line-read request (held until mN_gnt)
//   mN_gnt                 one-cycle pulse when the bus accepts N's request
//   mN_rvalid              response beat for requester N
//   resp_data, resp_last   shared response beat data / final-beat flag
//   bus_reqcyc/req/reqtag  bus request strobe, address, tag
//   bus_reqack             bus accepted the request
//   bus_respcyc/resp/tag   bus response beat strobe, data, tag
//   bus_respack            response beat acknowledge
//   timeout_err            sticky watchdog error
//
// Optional: define BUS_ARB_TIMEOUT_EN for the REQ/RESP watchdog and the
// response-tag filter. Without it timeout_err is tied low.

module bus_arbiter #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int BEATS          = 8,
  parameter int TIMEOUT        = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic [BUS_DATA_WIDTH-1:0] m0_addr,
  input  logic [BUS_TAG_WIDTH-1:0]  m0_tag,
  input  logic                      m1_req,
  input  logic [BUS_DATA_WIDTH-1:0] m1_addr,
  input  logic [BUS_TAG_WIDTH-1:0]  m1_tag,
  output logic                      m0_gnt,
  output logic                      m1_gnt,
  output logic                      m0_rvalid,
  output logic                      m1_rvalid,
  output logic [BUS_DATA_WIDTH-1:0] resp_data,
  output logic                      resp_last,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      timeout_err
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } state_t;

  state_t                    state;
  state_t                    state_n;
  logic                      owner;
  logic                      owner_n;
  logic                      rr_ptr;
  logic                      rr_n;
  logic [CW-1:0]             beat_cnt;
  logic [CW-1:0]             cnt_n;
  logic [BUS_DATA_WIDTH-1:0] req_n;
  logic [BUS_TAG_WIDTH-1:0]  tag_n;

  logic win;
  logic to_hit;
  logic tag_ok;
  logic ack;
  logic beat;
  logic last;

  // Contention goes to rr_ptr; otherwise the lone requester wins.
  assign win  = (m0_req & m1_req) ? rr_ptr : m1_req;

  // A watchdog expiry overrides any ack or beat in the same cycle.
  assign ack  = (state == REQ) & bus_reqack & ~to_hit;
  assign beat = (state == RESP) & bus_respcyc & tag_ok & ~to_hit;
  assign last = beat & (beat_cnt == CW'(BEATS - 1));

  assign bus_reqcyc  = (state == REQ);
  assign bus_respack = (state == RESP) & bus_respcyc;
  assign m0_gnt      = ack & ~owner;
  assign m1_gnt      = ack & owner;
  assign m0_rvalid   = beat & ~owner;
  assign m1_rvalid   = beat & owner;
  assign resp_data   = beat ? bus_resp : '0;
  assign resp_last   = last;

`ifdef BUS_ARB_TIMEOUT_EN
  logic [31:0] wd;
  logic        err;

  assign to_hit      = (state != IDLE) & (wd == 32'(TIMEOUT - 1));
  // Beats for another transaction are acked but not forwarded.
  assign tag_ok      = (bus_resptag == bus_reqtag);
  assign timeout_err = err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      if (state == IDLE) wd <= '0;
      else               wd <= wd + 32'd1;
      if (to_hit)        err <= 1'b1;
    end
  end
`else
  localparam int UNUSED_TIMEOUT = TIMEOUT;
  logic unused_tag;

  assign unused_tag  = ^bus_resptag;
  assign to_hit      = 1'b0;
  assign tag_ok      = 1'b1;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      rr_ptr     <= 1'b0;
      beat_cnt   <= '0;
      bus_req    <= '0;
      bus_reqtag <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      rr_ptr     <= rr_n;
      beat_cnt   <= cnt_n;
      bus_req    <= req_n;
      bus_reqtag <= tag_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = beat_cnt;
    req_n   = bus_req;
    tag_n   = bus_reqtag;
    unique case (state)
      IDLE: begin
        if (m0_req | m1_req) begin
          owner_n = win;
          req_n   = win ? m1_addr : m0_addr;
          tag_n   = win ? m1_tag : m0_tag;
          state_n = REQ;
        end
      end
      REQ: begin
        if (ack) begin
          rr_n    = ~owner;
          cnt_n   = '0;
          state_n = RESP;
        end
      end
      RESP: begin
        if (beat) begin
          cnt_n = beat_cnt + 1'b1;
          if (last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (to_hit) state_n = IDLE;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single system bus between two line-read requesters: port 0 is instruction fetch, port 1 is data memory.
- Sits between the fetch and memory-stage engines and the top-level bus_* pins.
- Grants one requester at a time and drives its address and tag onto the bus. Ownership is held until the full response burst returns; each beat is steered to the owner.
- Round-robin priority keeps fetch from starving data accesses, and the reverse.

Parameters:
- BUS_DATA_WIDTH, 64, bus data and address width
- BUS_TAG_WIDTH, 13, bus tag width
- BEATS, 8, response beats per transaction (one 512-bit line)
- TIMEOUT, 1024, watchdog cycle limit (optional feature only)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- m0_req, m1_req  in  1 each  request; held high until that port's mN_gnt
- m0_addr, m1_addr  in  BUS_DATA_WIDTH each  request address
- m0_tag, m1_tag  in  BUS_TAG_WIDTH each  request tag
- m0_gnt, m1_gnt  out  1 each  one-cycle pulse when the bus accepts the request
- m0_rvalid, m1_rvalid  out  1 each  response beat valid for that port
- resp_data  out  BUS_DATA_WIDTH  shared response beat data
- resp_last  out  1  final beat of the burst
- bus_reqcyc  out  1  bus request strobe
- bus_req  out  BUS_DATA_WIDTH  bus request address
- bus_reqtag  out  BUS_TAG_WIDTH  bus request tag
- bus_reqack  in  1  bus request accepted
- bus_respcyc  in  1  response beat present
- bus_respack  out  1  response beat acknowledge
- bus_resp  in  BUS_DATA_WIDTH  response beat data
- bus_resptag  in  BUS_TAG_WIDTH  response tag (unused except by the optional feature)
- timeout_err  out  1  sticky watchdog error (tied 0 without the optional feature)

Behaviour:
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE, owner=0, rr_ptr=0 (port 0 favoured next), beat_cnt=0.
  - All outputs 0: bus_reqcyc, bus_req, bus_reqtag, gnt, rvalid, resp_data, resp_last, bus_respack, timeout_err.
- States: IDLE, REQ, RESP.
- IDLE:
  - If only one port requests, it wins.
  - If both request, the port indicated by rr_ptr wins.
  - On a win: latch the winner's addr/tag into bus_req/bus_reqtag, set owner, go to REQ. bus_reqcyc is registered, so it rises the cycle after the request is sampled (one cycle of arbitration latency).
- REQ:
  - Hold bus_reqcyc, bus_req and bus_reqtag stable until bus_reqack.
  - On the bus_reqack cycle: pulse the owner's gnt for one cycle, deassert bus_reqcyc next cycle, set rr_ptr = ~owner, clear beat_cnt, go to RESP.
- RESP:
  - bus_respack = bus_respcyc (combinational).
  - Each bus_respcyc cycle:
    - resp_data = bus_resp and m<owner>_rvalid = 1, both combinational with zero latency.
    - beat_cnt increments, width clog2(BEATS), wrapping.
  - resp_last = 1 when beat_cnt == BEATS-1 and bus_respcyc is high; on that cycle go to IDLE.
  - Gaps (bus_respcyc low) are allowed: hold state, rvalid=0.
- A new arbitration may start in the IDLE cycle immediately after resp_last. Back-to-back transactions therefore have 1 idle cycle between the last beat and the next bus_reqcyc.
- bus_respcyc in IDLE or REQ is a stray beat: not acknowledged (bus_respack=0) and not forwarded.
- A requester dropping mN_req while in REQ does not cancel: the latched request completes and its beats are still delivered.
- The non-owner's rvalid is always 0. gnt never pulses for both ports in the same cycle.

Optional Feature:
- Macro: BUS_ARB_TIMEOUT_EN.
- When defined:
  - A 32-bit watchdog counts cycles spent in REQ or RESP and clears on entry to IDLE.
  - On reaching TIMEOUT: set timeout_err (sticky until reset), abandon the transaction (drop bus_reqcyc, no further rvalid), return to IDLE.
  - In RESP, a beat whose bus_resptag differs from the latched bus_reqtag is acknowledged and dropped, with no rvalid.
- When undefined: no counter, no tag check, timeout_err tied 0, and the arbiter waits indefinitely.

Test Plan:
- m0 only, addr 0x1000, tag 0x100; reqack 2 cycles after bus_reqcyc; 8 beats 0x11..0x88 -> m0_gnt single pulse; m0_rvalid for 8 beats with resp_data matching; resp_last on 0x88; m1_rvalid always 0.
- m0 and m1 both requesting from reset -> m0 served first, then m1 (bus_req=m1_addr) with exactly 1 idle cycle after m0's resp_last; if m0 re-requests meanwhile, the third grant goes to m1 only if rr_ptr favours it (check that the order alternates 0,1,0,1 over 4 transactions).
- Response with 3 gap cycles between beats 4 and 5 -> beat_cnt holds, resp_last still on the 8th valid beat, rvalid low during gaps.
- Stray bus_respcyc in IDLE -> bus_respack=0, no rvalid, state stays IDLE.
- Reset asserted at beat 5 of a burst -> outputs 0 immediately (asynchronously); after release, a new m1 request is served normally starting at beat 0.
- BUS_ARB_TIMEOUT_EN, TIMEOUT=16, reqack never asserted -> after 16 cycles bus_reqcyc drops, timeout_err=1 and stays 1; the next request is arbitrated normally.
